// File: rtl/ones_count_accumulator_if.sv
// Beat input and frame-result output bundle for ones_count_accumulator.
// The producer/consumer side uses master; the accumulator uses slave.
interface ones_count_accumulator_if #(
  parameter int SUM_W = 6,
  parameter int LEN_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_count;
  logic             in_last;
  logic [SUM_W-1:0] threshold;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] out_sum;
  logic [LEN_W-1:0] out_len;
  logic             out_over;
  logic             err_range;

  modport master (
    output in_valid, in_count, in_last, threshold, out_ready,
    input  in_ready, out_valid, out_sum, out_len, out_over, err_range
  );

  modport slave (
    input  in_valid, in_count, in_last, threshold, out_ready,
    output in_ready, out_valid, out_sum, out_len, out_over, err_range
  );
endinterface

// File: rtl/ones_count_accumulator.sv
// Sums per-beat ones counts over a frame, then holds the saturated total,
// the beat count and the threshold flag until the consumer takes them.
module ones_count_accumulator #(
  parameter int FRAME_LEN = 8,
  parameter int SUM_W     = 6,
  parameter int LEN_W     = 4
) (
  input logic                       clk,
  input logic                       rst_n,
  ones_count_accumulator_if.slave   bus
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           r_state;
  logic [SUM_W-1:0] r_acc;
  logic [LEN_W-1:0] r_cnt;
  logic [SUM_W-1:0] r_sum;
  logic [LEN_W-1:0] r_len;
  logic             r_over;
  logic             r_err;

  logic             w_bad;
  logic [2:0]       w_clamped;
  logic [SUM_W:0]   w_add;
  logic [SUM_W-1:0] w_accSat;
  logic [LEN_W-1:0] w_cntNext;
  logic             w_close;

  // Out-of-range counts are treated as the largest legal count (4).
  assign w_bad     = bus.in_count > 3'd4;
  assign w_clamped = w_bad ? 3'd4 : bus.in_count;
  assign w_add     = {1'b0, r_acc} + {{(SUM_W-2){1'b0}}, w_clamped};
  assign w_accSat  = w_add[SUM_W] ? {SUM_W{1'b1}} : w_add[SUM_W-1:0];
  assign w_cntNext = r_cnt + LEN_W'(1);
  assign w_close   = bus.in_last || (w_cntNext == LEN_W'(FRAME_LEN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_len   <= '0;
      r_over  <= 1'b0;
      r_err   <= 1'b0;
    end else if (r_state == ACCUM) begin
      if (bus.in_valid) begin
        if (w_bad) r_err <= 1'b1;
        if (w_close) begin
          r_sum   <= w_accSat;
          r_len   <= w_cntNext;
          r_over  <= (w_accSat >= bus.threshold);
          r_acc   <= '0;
          r_cnt   <= '0;
          r_state <= HOLD;
        end else begin
          r_acc <= w_accSat;
          r_cnt <= w_cntNext;
        end
      end
    end else if (bus.out_ready) begin
      r_state <= ACCUM;
    end
  end

  // in_ready depends only on state, so out_ready never reaches it combinationally.
  assign bus.out_valid = (r_state == HOLD);
  assign bus.in_ready  = (r_state == ACCUM);
  assign bus.out_sum   = r_sum;
  assign bus.out_len   = r_len;
  assign bus.out_over  = r_over;
  assign bus.err_range = r_err;

endmodule

// File: tb/tb_ones_count_accumulator.sv
// Directed bench for ones_count_accumulator: a frame-level model checked every
// cycle, literal frame results, and a narrow SUM_W=4 build for saturation.
module tb_ones_count_accumulator;

  localparam int FRAME_LEN = 8;
  localparam int SUM_W     = 6;
  localparam int LEN_W     = 4;
  localparam int SUM_MAX   = (1 << SUM_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nChecks = 0;
  int   nErrors = 0;

  always #5 clk = ~clk;

  ones_count_accumulator_if #(.SUM_W(SUM_W), .LEN_W(LEN_W)) busA ();
  ones_count_accumulator_if #(.SUM_W(4), .LEN_W(4)) busB ();

  ones_count_accumulator #(.FRAME_LEN(FRAME_LEN), .SUM_W(SUM_W), .LEN_W(LEN_W)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busA.slave)
  );

  ones_count_accumulator #(.FRAME_LEN(8), .SUM_W(4), .LEN_W(4)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busB.slave)
  );

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: running total and beat count, result computed when a frame closes.
  logic mValid = 1'b0;
  int   mSum = 0, mLen = 0, mOver = 0, mErr = 0;
  int   mTotal = 0, mBeats = 0;

  always @(posedge clk or negedge rst_n) begin
    int c, total, n, sat;
    if (!rst_n) begin
      mValid <= 1'b0;
      mSum   <= 0;
      mLen   <= 0;
      mOver  <= 0;
      mErr   <= 0;
      mTotal <= 0;
      mBeats <= 0;
    end else if (!mValid) begin
      if (busA.in_valid) begin
        c     = (busA.in_count > 4) ? 4 : int'(busA.in_count);
        total = mTotal + c;
        n     = mBeats + 1;
        if (busA.in_count > 4) mErr <= 1;
        if (busA.in_last || n == FRAME_LEN) begin
          sat    = (total > SUM_MAX) ? SUM_MAX : total;
          mSum   <= sat;
          mLen   <= n;
          mOver  <= (sat >= int'(busA.threshold)) ? 1 : 0;
          mValid <= 1'b1;
          mTotal <= 0;
          mBeats <= 0;
        end else begin
          mTotal <= total;
          mBeats <= n;
        end
      end
    end else if (busA.out_ready) begin
      mValid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checkVal("cmpInReady", busA.in_ready, !mValid);
      checkVal("cmpOutValid", busA.out_valid, mValid);
      checkVal("cmpErr", busA.err_range, mErr);
      if (mValid) begin
        checkVal("cmpSum", busA.out_sum, mSum);
        checkVal("cmpLen", busA.out_len, mLen);
        checkVal("cmpOver", busA.out_over, mOver);
      end
    end
  end

  task automatic applyStimulus(input logic v, input logic [2:0] c, input logic l, input logic r);
    @(negedge clk);
    #1;
    busA.in_valid  = v;
    busA.in_count  = c;
    busA.in_last   = l;
    busA.out_ready = r;
  endtask

  task automatic checkOutput(input string name, input int expSum, input int expLen, input int expOver);
    checkVal({name, "_valid"}, busA.out_valid, 1);
    checkVal({name, "_sum"}, busA.out_sum, expSum);
    checkVal({name, "_len"}, busA.out_len, expLen);
    checkVal({name, "_over"}, busA.out_over, expOver);
  endtask

  task automatic checkResetState(input string name);
    checkVal({name, "_inReady"}, busA.in_ready, 1);
    checkVal({name, "_outValid"}, busA.out_valid, 0);
    checkVal({name, "_sum"}, busA.out_sum, 0);
    checkVal({name, "_len"}, busA.out_len, 0);
    checkVal({name, "_over"}, busA.out_over, 0);
    checkVal({name, "_err"}, busA.err_range, 0);
  endtask

  initial begin
    logic [2:0] fullCounts [8];
    fullCounts = '{3'd0, 3'd3, 3'd2, 3'd4, 3'd2, 3'd0, 3'd1, 3'd4};

    busA.in_valid  = 1'b1;
    busA.in_count  = 3'd4;
    busA.in_last   = 1'b0;
    busA.threshold = '0;
    busA.out_ready = 1'b0;
    busB.in_valid  = 1'b0;
    busB.in_count  = 3'd0;
    busB.in_last   = 1'b0;
    busB.threshold = '0;
    busB.out_ready = 1'b0;

    // Reset held while a valid beat of 4 is offered.
    repeat (3) @(negedge clk);
    checkResetState("reset");
    #1;
    busA.in_valid = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Full 8-beat frame, then a beat held across the handshake.
    busA.threshold = 6'd16;
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, fullCounts[i], 1'b0, 1'b1);
    applyStimulus(1'b1, 3'd2, 1'b1, 1'b1);
    checkOutput("full8", 16, 8, 1);
    checkVal("full8_inReady", busA.in_ready, 0);
    applyStimulus(1'b1, 3'd2, 1'b1, 1'b1);
    checkVal("handshake_outValid", busA.out_valid, 0);
    checkVal("handshake_inReady", busA.in_ready, 1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    checkOutput("oneBeat", 2, 1, 0);

    // Early close with in_last.
    busA.threshold = 6'd13;
    applyStimulus(1'b1, 3'd4, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'd4, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'd4, 1'b1, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    checkOutput("last3", 12, 3, 0);

    // Consumer stalls while the producer keeps toggling in_valid.
    busA.threshold = 6'd5;
    applyStimulus(1'b1, 3'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd2, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i[0], 3'd3, 1'b1, 1'b0);
      checkOutput("stall", 3, 2, 0);
      checkVal("stall_inReady", busA.in_ready, 0);
    end
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    checkOutput("stallRelease", 3, 2, 0);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    checkVal("stallDrop_outValid", busA.out_valid, 0);
    applyStimulus(1'b1, 3'd1, 1'b1, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    checkOutput("afterStall", 1, 1, 0);

    // Out-of-range count is clamped and leaves a sticky error.
    busA.threshold = 6'd0;
    applyStimulus(1'b1, 3'd7, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'd1, 1'b1, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    checkOutput("clamp", 5, 2, 1);
    checkVal("clamp_err", busA.err_range, 1);
    applyStimulus(1'b1, 3'd3, 1'b1, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    checkOutput("postErr", 3, 1, 1);
    checkVal("postErr_err", busA.err_range, 1);

    // Reset mid-frame discards the partial frame.
    busA.threshold = 6'd3;
    applyStimulus(1'b1, 3'd4, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'd4, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'd4, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    busA.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkResetState("midReset");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 3'd2, 1'b1, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    checkOutput("afterReset", 2, 1, 0);

    // Narrow build: eight beats of 4 saturate a 4-bit sum at 15.
    busB.threshold = 4'd15;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      busB.in_valid  = 1'b1;
      busB.in_count  = 3'd4;
      busB.out_ready = 1'b1;
    end
    @(negedge clk);
    #1;
    busB.in_valid = 1'b0;
    checkVal("sat_valid", busB.out_valid, 1);
    checkVal("sat_sum", busB.out_sum, 15);
    checkVal("sat_len", busB.out_len, 8);
    checkVal("sat_over", busB.out_over, 1);
    @(negedge clk);
    #1;
    checkVal("sat_done", busB.out_valid, 0);

    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
